// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared definitions for the buffered RS232 transmitter:
//                transmit FSM state encoding, parity-sense constants,
//                baud divisor helper and DATA_BITS legality check.
//  Config      : RS232_PARITY_EN - adds the PARITY state to the encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

`ifdef RS232_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } tx_state_t;
`endif

    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    // Bit period in clocks, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic bit data_bits_legal(input int n);
        return (n >= 5) && (n <= 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_fifo
//  Description : Synchronous FIFO with registered full/empty flags. Pointers
//                carry one extra bit so full and empty can be told apart.
//                Pushes while full and pops while empty are ignored.
//  Ports       : clk, rst (async, active-high)
//                push, wdata[WIDTH]  - write side
//                pop, rdata[WIDTH]   - read side, rdata shows the head word
//                full, empty         - registered status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic [c_AW:0]    w_wr_ptr_next;
    logic [c_AW:0]    w_rd_ptr_next;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push     = push & ~r_full;
    assign w_do_pop      = pop & ~r_empty;
    assign w_wr_ptr_next = r_wr_ptr + {{c_AW{1'b0}}, w_do_push};
    assign w_rd_ptr_next = r_rd_ptr + {{c_AW{1'b0}}, w_do_pop};

    // Flags are computed from the next pointers so they are exact in the
    // cycle right after the push or pop that changes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_empty  <= (w_wr_ptr_next == w_rd_ptr_next);
            r_full   <= (w_wr_ptr_next[c_AW] != w_rd_ptr_next[c_AW]) &&
                        (w_wr_ptr_next[c_AW-1:0] == w_rd_ptr_next[c_AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr[c_AW-1:0]];
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/rs232_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_tx_buffered
//  Description : Buffered RS232 transmitter. Words written with data_ready
//                are queued in a FIFO and sent LSB-first on tx, framed by a
//                start bit, optional parity and STOP_BITS stop bits. A new
//                frame only starts while cts is high; frames in flight always
//                complete.
//  Config      : RS232_PARITY_EN - when defined, one parity bit per frame
//                (sense chosen by PARITY_ODD).
//  Ports       : clk, rst (async, active-high)
//                data_ready, data[DATA_BITS] - write strobe and word
//                cts      - clear-to-send, sampled at frame start
//                full     - FIFO full, writes dropped while high
//                overflow - one-cycle pulse per dropped write
//                rts      - FIFO non-empty or frame in progress
//                tx       - serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_tx_buffered #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_ready,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 cts,
    output logic                 full,
    output logic                 overflow,
    output logic                 rts,
    output logic                 tx
);

    import rs232_pkg::*;

    localparam int                 c_DIV      = baud_div(CLK_HZ, BAUD);
    localparam int                 c_CNT_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [2:0]         c_LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]         c_LAST_STOP = 3'(STOP_BITS - 1);

    generate
        if (!data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
            $error("rs232_tx_buffered: DATA_BITS must be 5..8");
        end
        if (c_DIV < 2) begin : g_bad_div
            $error("rs232_tx_buffered: bit period must be at least 2 clocks");
        end
    endgenerate

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_tc;
    logic                 w_tx_next;
    logic                 r_tx;
    logic                 r_overflow;

`ifdef RS232_PARITY_EN
    localparam logic c_PAR_SENSE = (PARITY_ODD != 0) ? c_PARITY_ODD : c_PARITY_EVEN;
    logic r_parity;
`else
    logic w_unused_parity_cfg;
    assign w_unused_parity_cfg = (PARITY_ODD != 0);
`endif

    rs232_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_ready),
        .pop   (w_pop),
        .wdata (data),
        .rdata (w_head),
        .full  (full),
        .empty (w_empty)
    );

    assign w_tc = (r_baud_cnt == c_CNT_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // The pop is issued in the same cycle the FSM decides to start a frame,
    // both from IDLE and at the end of a stop bit (back-to-back frames).
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && cts) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tc) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tc && (r_bit_cnt == c_LAST_DATA)) begin
`ifdef RS232_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef RS232_PARITY_EN
            ST_PARITY: begin
                if (w_tc) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tc && (r_bit_cnt == c_LAST_STOP)) begin
                    if (!w_empty && cts) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- output
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = r_shift[0];
`ifdef RS232_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------- datapath
    // r_bit_cnt indexes data bits while in DATA and stop bits while in STOP;
    // it clears on every state change so each phase starts counting at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
`ifdef RS232_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_tx       <= w_tx_next;
            r_overflow <= data_ready & full;
            if (w_pop) begin
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
                r_shift    <= w_head;
`ifdef RS232_PARITY_EN
                r_parity   <= (^w_head) ^ c_PAR_SENSE;
`endif
            end else if (r_state != ST_IDLE) begin
                if (w_tc) begin
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= (w_state_next != r_state) ? 3'd0 : r_bit_cnt + 3'd1;
                    if (r_state == ST_DATA) begin
                        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign rts      = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire
